// File: rtl/core_pkg.sv
// Shared fetch-path types and constants for the pipelined RISC-V core.
package core_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetchq_ptr_ctrl.sv
// Read/write pointers and occupancy for the fetch queue; 1-cycle update, flush clears next edge.
// Caller qualifies push/pop; this block never sees a push while full.
module fetchq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  import core_pkg::*;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode queue: push->Out_Valid 1 cycle (0 with INSTR_FETCH_QUEUE_BYPASS_EN when empty).
// PC_Stall back-pressures fetch when full; pushes while full are dropped; Flush empties next edge.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = core_pkg::PC_W,
  parameter int INSTR_W = core_pkg::INSTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   In_Valid,
  input  logic [PC_W-1:0]        In_PC,
  input  logic [INSTR_W-1:0]     In_Instr,
  output logic                   PC_Stall,
  input  logic                   Out_Ready,
  output logic                   Out_Valid,
  output logic [PC_W-1:0]        Out_PC,
  output logic [INSTR_W-1:0]     Out_Instr,
  input  logic                   Flush,
  output logic [$clog2(DEPTH):0] Count
);
  import core_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && In_Valid && Out_Ready && !Flush && !reset;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed directly by decode and never stored.
  assign push = In_Valid && !full && !Flush && !bypass;
  assign pop  = !empty && Out_Ready && !Flush;

  fetchq_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk    (clk),
    .reset  (reset),
    .flush  (Flush),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (Count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= In_PC;
      instr_mem[wr_ptr] <= In_Instr;
    end
  end

  // Unreset storage is masked while empty so no X reaches decode.
  always_comb begin
    Out_Valid = !empty;
    Out_PC    = '0;
    Out_Instr = '0;
    if (bypass) begin
      Out_Valid = 1'b1;
      Out_PC    = In_PC;
      Out_Instr = In_Instr;
    end else if (!empty) begin
      Out_PC    = pc_mem[rd_ptr];
      Out_Instr = instr_mem[rd_ptr];
    end
  end

  assign PC_Stall = full;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised plus directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
  import core_pkg::*;

  localparam int DEPTH = 4;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic                   In_Valid;
  logic [PC_W-1:0]        In_PC;
  logic [INSTR_W-1:0]     In_Instr;
  logic                   PC_Stall;
  logic                   Out_Ready;
  logic                   Out_Valid;
  logic [PC_W-1:0]        Out_PC;
  logic [INSTR_W-1:0]     Out_Instr;
  logic                   Flush;
  logic [$clog2(DEPTH):0] Count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .In_PC     (In_PC),
    .In_Instr  (In_Instr),
    .PC_Stall  (PC_Stall),
    .Out_Ready (Out_Ready),
    .Out_Valid (Out_Valid),
    .Out_PC    (Out_PC),
    .Out_Instr (Out_Instr),
    .Flush     (Flush),
    .Count     (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return pc[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Reference model: an ordered list of held entries, updated on each rising edge.
  fetch_entry_t q[$];
  bit           started = 1'b0;
  fetch_entry_t ent;
  bit           m_byp, m_push, m_pop;

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      q.delete();
    end else if (Flush) begin
      q.delete();
    end else begin
      m_byp  = BYP && q.size() == 0 && In_Valid && Out_Ready;
      m_push = In_Valid && q.size() < DEPTH && !m_byp;
      m_pop  = q.size() != 0 && Out_Ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        ent.pc    = In_PC;
        ent.instr = In_Instr;
        q.push_back(ent);
      end
    end
  end

  int  c_n;
  bit  c_byp;
  always @(negedge clk) begin
    if (started) begin
      c_n   = q.size();
      c_byp = BYP && c_n == 0 && In_Valid && Out_Ready && !Flush && !reset;
      check("model_count", 64'(Count), 64'(c_n));
      check("model_stall", 64'(PC_Stall), 64'(c_n == DEPTH));
      check("model_valid", 64'(Out_Valid), 64'(c_n != 0 || c_byp));
      if (c_n != 0) begin
        check("model_pc", Out_PC, q[0].pc);
        check("model_instr", 64'(Out_Instr), 64'(q[0].instr));
      end else if (c_byp) begin
        check("model_byp_pc", Out_PC, In_PC);
        check("model_byp_instr", 64'(Out_Instr), 64'(In_Instr));
      end else begin
        check("model_empty_pc", Out_PC, 64'h0);
        check("model_empty_instr", 64'(Out_Instr), 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
    In_Valid  = v;
    In_PC     = pc;
    In_Instr  = instr_of(pc);
    Out_Ready = rdy;
    Flush     = fl;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_count", 64'(Count), 64'd0);
    check("reset_valid", 64'(Out_Valid), 64'd0);
    check("reset_stall", 64'(PC_Stall), 64'd0);
    check("reset_pc", Out_PC, 64'd0);
    check("reset_instr", 64'(Out_Instr), 64'd0);

    // Fill to DEPTH with decode stalled, then try one more.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(i * 4), 1'b0, 1'b0);
      step();
    end
    check("full_count", 64'(Count), 64'd4);
    check("full_stall", 64'(PC_Stall), 64'd1);
    drive(1'b1, 64'd16, 1'b0, 1'b0);
    step();
    check("drop_count", 64'(Count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("pop_order_pc", Out_PC, 64'(i * 4));
      step();
      if (i == 0) check("stall_release", 64'(PC_Stall), 64'd0);
    end
    check("drained_valid", 64'(Out_Valid), 64'd0);

    // Steady stream over pointer wrap with two entries in hand.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h200 + 64'(i * 4), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 64'h208 + 64'(k * 4), 1'b1, 1'b0);
      check("stream_pc", Out_PC, 64'h200 + 64'(k * 4));
      step();
      check("stream_count", 64'(Count), 64'd2);
    end
    drain();

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h300 + 64'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'h40, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("flush_count", 64'(Count), 64'd0);
    check("flush_valid", 64'(Out_Valid), 64'd0);
    step();
    check("flush_no_0x40", 64'(Out_Valid), 64'd0);

    // Reset while full with push and pop active.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h500 + 64'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'h600, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rst_full_count", 64'(Count), 64'd0);
    check("rst_full_stall", 64'(PC_Stall), 64'd0);

    // Empty-queue latency.
    drive(1'b1, 64'h100, 1'b1, 1'b0);
    #1;
    if (BYP) begin
      check("byp_same_valid", 64'(Out_Valid), 64'd1);
      check("byp_same_pc", Out_PC, 64'h100);
    end else begin
      check("nobyp_same_valid", 64'(Out_Valid), 64'd0);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    if (BYP) begin
      check("byp_next_count", 64'(Count), 64'd0);
    end else begin
      check("nobyp_next_valid", 64'(Out_Valid), 64'd1);
      check("nobyp_next_pc", Out_PC, 64'h100);
    end
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Decoupling queue between fetch (Program_Counter plus instruction memory) and decode in the pipelined RISC-V core. Buffers up to DEPTH {PC, instruction} pairs, back-pressures fetch through a stall output, and discards all contents on a branch/jump redirect. It is the consuming end of the fetch path: the program counter produces addresses, this block accepts what those addresses fetched.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 64, PC width
- INSTR_W, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- In_Valid  input  1  fetch presents a valid entry this cycle
- In_PC  input  PC_W  PC of fetched instruction
- In_Instr  input  INSTR_W  fetched instruction
- PC_Stall  output  1  fetch must hold PC; high when queue full
- Out_Ready  input  1  decode accepts head this cycle
- Out_Valid  output  1  head entry valid
- Out_PC  output  PC_W  head PC
- Out_Instr  output  INSTR_W  head instruction
- Flush  input  1  redirect: discard all entries and the incoming entry
- Count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer, write pointer, read pointer and occupancy counter; pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
- Push = In_Valid && !full && !Flush; pop = Out_Valid && Out_Ready && !Flush.
- Push and pop in the same cycle: both occur, Count unchanged; legal even when full only if pop is also present? No: full uses registered state, so a push while full is dropped and PC_Stall is already high; fetch must not advance.
- PC_Stall = (Count == DEPTH), combinational from registered Count.
- Out_Valid = (Count != 0); Out_PC/Out_Instr driven from storage at read pointer.
- Flush: next cycle pointers = 0, Count = 0, Out_Valid = 0; overrides push and pop in that cycle.
- Storage array not reset; only pointers and Count.
- Head output when Out_Valid = 0 is don't-care but must not be X-propagating into control: Out_Valid gates use.

## Timing
- Reset values: Count = 0, Out_Valid = 0, PC_Stall = 0, Out_PC = 0, Out_Instr = 0 (outputs forced to zero while empty).
- Latency push → Out_Valid: 1 cycle (no bypass build).
- PC_Stall asserts the cycle after the DEPTH-th push; deasserts the cycle after the first pop from full.
- Reset or Flush mid-stream: queue empty on the following edge; entries in flight lost.
- Reset has priority over Flush; Flush over push/pop.

## Configuration
- INSTR_FETCH_QUEUE_BYPASS_EN defined: when Count == 0, In_Valid = 1, Out_Ready = 1 and no Flush, input passes combinationally to Out_PC/Out_Instr with Out_Valid = 1 and is not written; zero-cycle latency when empty.
- Not defined: every entry is written and appears one cycle later; outputs purely registered-state based.

## Structure
- Shared package (core_pkg): PC_W, INSTR_W constants, fetch_entry_t typedef {pc, instr}, NOP_INSTR = 32'h00000013.
- One sub-module natural: fetchq_ptr_ctrl (pointers, Count, full/empty); storage and output mux in top.

## Test plan
- Reset then idle: Count = 0, Out_Valid = 0, PC_Stall = 0, Out_PC = 0.
- Push PCs 0,4,8,12 with Out_Ready = 0 → Count = 4, PC_Stall = 1; push of PC 16 dropped; then pop four → outputs 0,4,8,12 in order, PC_Stall low after first pop.
- Continuous push and pop with 2 preloaded entries for 20 cycles → Count stays 2, order preserved across pointer wrap.
- Load 3 entries, assert Flush together with In_Valid (PC 0x40) and Out_Ready → next cycle Count = 0, Out_Valid = 0, PC 0x40 not present.
- Assert reset while full with push and pop active → next cycle Count = 0, PC_Stall = 0.
- Bypass build: empty queue, In_Valid with PC 0x100 and Out_Ready → same cycle Out_Valid = 1, Out_PC = 0x100, Count stays 0; non-bypass build → Out_PC = 0x100 one cycle later.
